// File: rtl/uart_transmitter.sv
// uart_transmitter
//   8N1 UART transmitter: start bit, eight data bits LSB first, one stop bit.
//   Bit period is CLK_FREQ/BAUD clock cycles (floor division).
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   data_in        byte to send, sampled on the accepting edge only
//   data_in_valid  producer offers a byte
//   data_in_ready  high only in IDLE
//   serial_out     registered UART line, idles high
//   tx_busy        high whenever a frame is in progress
module uart_transmitter #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    output logic       tx_busy
);

    localparam int CYCLES_PER_SYMBOL = CLK_FREQ / BAUD;
    // Guarded so the width stays legal long enough for the check below to fire.
    localparam int CNT_W = (CYCLES_PER_SYMBOL < 2) ? 1 : $clog2(CYCLES_PER_SYMBOL);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES_PER_SYMBOL - 1);

    if (CYCLES_PER_SYMBOL < 2) begin : g_bad_rate
        $error("uart_transmitter: CLK_FREQ/BAUD must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             so_q, so_d;
    logic             sym_end;

    assign sym_end = (cnt_q == CNT_MAX);

    // serial_out_d always reflects the line level of the state being entered,
    // so the registered output lines up with the state without an extra cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        so_d    = so_q;
        if (state_q == IDLE || sym_end) cnt_d = '0;
        else                            cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                so_d = 1'b1;
                if (data_in_valid) begin
                    state_d = START;
                    shreg_d = data_in;
                    cnt_d   = '0;
                    so_d    = 1'b0;
                end
            end
            START: begin
                if (sym_end) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    so_d    = shreg_q[0];
                end
            end
            DATA: begin
                if (sym_end) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        idx_d   = 3'd0;
                        so_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        so_d  = shreg_q[1];   // next bit after the shift
                    end
                end
            end
            STOP: begin
                if (sym_end) begin
                    state_d = IDLE;
                    so_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                so_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shreg_q <= 8'h00;
            so_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            so_q    <= so_d;
        end
    end

    assign serial_out    = so_q;
    assign data_in_ready = (state_q == IDLE);
    assign tx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a fast instance (C=8) for the
// functional cases and a default-parameter instance (C=434).
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;

    logic [7:0] d_s = 8'h00, d_d = 8'h00;
    logic       v_s = 1'b0, v_d = 1'b0;
    logic       rdy_s, so_s, busy_s;
    logic       rdy_d, so_d, busy_d;

    int n_tests = 0;
    int n_fail  = 0;

    uart_transmitter #(.CLK_FREQ(80), .BAUD(10)) u_small (
        .clk(clk), .rst(rst), .data_in(d_s), .data_in_valid(v_s),
        .data_in_ready(rdy_s), .serial_out(so_s), .tx_busy(busy_s));

    uart_transmitter u_def (
        .clk(clk), .rst(rst), .data_in(d_d), .data_in_valid(v_d),
        .data_in_ready(rdy_d), .serial_out(so_d), .tx_busy(busy_d));

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic logic [2:0] outs(input bit def);
        return def ? {so_d, busy_d, rdy_d} : {so_s, busy_s, rdy_s};
    endfunction

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: {line,busy,ready} got %b want %b", tag, obs, exp);
        end
    endtask

    // Offer a byte and wait (bounded) for the accepting edge; returns #1 after it.
    task automatic accept(input bit def, input logic [7:0] b);
        int waited = 0;
        if (def) begin d_d = b; v_d = 1'b1; end
        else     begin d_s = b; v_s = 1'b1; end
        @(negedge clk);
        while (outs(def)[0] !== 1'b1 && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20000) chk("accept_timeout", outs(def), 3'b101);
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the accepting edge; checks every cycle of the frame,
    // then the single idle cycle that follows it.
    task automatic check_frame(input bit def, input int c, input logic [7:0] b, input string tag);
        logic exp_bit;
        for (int sym = 0; sym < 10; sym++) begin
            if (sym == 0)      exp_bit = 1'b0;
            else if (sym == 9) exp_bit = 1'b1;
            else               exp_bit = b[sym-1];
            for (int k = 0; k < c; k++) begin
                if (!(sym == 0 && k == 0)) begin
                    @(posedge clk);
                    #1;
                end
                chk(tag, outs(def), {exp_bit, 2'b10});
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, outs(def), 3'b101);
    endtask

    initial begin
        // Reset with no clock running.
        #1 rst = 1'b1;
        #1;
        chk("reset_small", outs(0), 3'b101);
        chk("reset_def",   outs(1), 3'b101);
        #2 rst = 1'b0;
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_reset", outs(0), 3'b101);

        // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1 and busy for 80 cycles.
        accept(0, 8'hA5);
        v_s = 1'b0;
        check_frame(0, 8, 8'hA5, "a5");

        // Back-to-back 0x00 then 0xFF with valid held; second accept at T+81.
        accept(0, 8'h00);
        d_s = 8'hFF;
        check_frame(0, 8, 8'h00, "b2b_00");
        @(posedge clk);
        #1;
        v_s = 1'b0;
        check_frame(0, 8, 8'hFF, "b2b_ff");

        // Busy protection during a 0x3C frame.
        accept(0, 8'h3C);
        v_s = 1'b0;
        d_s = 8'h99;
        fork
            check_frame(0, 8, 8'h3C, "busy_3c");
            begin
                repeat (20) @(negedge clk);
                d_s = 8'hFF; v_s = 1'b1;
                @(negedge clk);
                v_s = 1'b0; d_s = 8'h00;
                repeat (30) @(negedge clk);
                d_s = 8'h12; v_s = 1'b1;
                repeat (3) @(negedge clk);
                v_s = 1'b0;
            end
        join

        // Mid-frame reset during data bit 3 of 0x0F.
        accept(0, 8'h0F);
        v_s = 1'b0;
        repeat (35) @(posedge clk);
        #1;
        chk("pre_reset_bit3", outs(0), 3'b110);
        #1 rst = 1'b1;
        #1;
        chk("async_reset", outs(0), 3'b101);
        @(negedge clk);
        d_s = 8'h55; v_s = 1'b1;           // handshake under reset is ignored
        @(posedge clk);
        #1;
        chk("held_reset", outs(0), 3'b101);
        @(negedge clk);
        v_s = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after_release", outs(0), 3'b101);
        accept(0, 8'h81);
        v_s = 1'b0;
        check_frame(0, 8, 8'h81, "post_reset_81");

        // Default parameters: 434-cycle bits, 4341-cycle frame period.
        accept(1, 8'h55);
        check_frame(1, 434, 8'h55, "def_55a");
        @(posedge clk);
        #1;
        v_d = 1'b0;
        check_frame(1, 434, 8'h55, "def_55b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
